// File: rtl/sort4_ctrl_if.sv
// sort4_ctrl byte stream bus: upstream producer and downstream consumer.
// Producer side drives master, the sorter takes the slave view.
interface sort4_ctrl_if;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;

  modport master (
    output in_data,
    output in_valid,
    output out_ready,
    input  in_ready,
    input  out_data,
    input  out_valid
  );

  modport slave (
    input  in_data,
    input  in_valid,
    input  out_ready,
    output in_ready,
    output out_data,
    output out_valid
  );
endinterface

// File: rtl/sort4_ctrl.sv
// sort4_ctrl: load 4 bytes, bubble-sort them on one shared comparator, stream out.
// Optional macro SORT_DESCENDING_EN flips the order to largest-first.
module comparator8_bit (
  input  logic [7:0] a_i,
  input  logic [7:0] b_i,
  input  logic       lt_i,
  input  logic       eq_i,
  input  logic       gt_i,
  output logic       lt_o,
  output logic       eq_o,
  output logic       gt_o
);
  // Magnitude compare; equal operands pass the cascade through.
  always_comb begin
    lt_o = 1'b0;
    eq_o = 1'b0;
    gt_o = 1'b0;
    if (a_i > b_i) begin
      gt_o = 1'b1;
    end else if (a_i < b_i) begin
      lt_o = 1'b1;
    end else begin
      lt_o = lt_i;
      eq_o = eq_i;
      gt_o = gt_i;
    end
  end
endmodule

module sort4_ctrl (
  input  logic       clk,
  input  logic       rst_n,
  sort4_ctrl_if.slave bus,
  output logic       busy,
  output logic [2:0] swap_cnt
);
  typedef enum logic [1:0] {
    S_LOAD  = 2'd0,
    S_SORT  = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t     state_q;
  logic [7:0] buf_q [4];
  logic [1:0] ld_idx_q;
  logic [2:0] step_q;
  logic [1:0] out_idx_q;
  logic [2:0] swap_cnt_q;
  logic       in_ready_q;
  logic       out_valid_q;
  logic       busy_q;

  logic [1:0] pair_d;
  logic [1:0] pair_nx_d;
  logic [7:0] cmp_a_d;
  logic [7:0] cmp_b_d;
  logic       cmp_lt;
  logic       cmp_eq;
  logic       cmp_gt;
  logic       swap_d;

  // Bubble schedule: step -> lower index of the compared pair.
  always_comb begin
    pair_d = 2'd2;
    case (step_q)
      3'd0, 3'd3, 3'd5: pair_d = 2'd0;
      3'd1, 3'd4:       pair_d = 2'd1;
      default:          pair_d = 2'd2;
    endcase
  end

  assign pair_nx_d = pair_d + 2'd1;
  assign cmp_a_d   = buf_q[pair_d];
  assign cmp_b_d   = buf_q[pair_nx_d];

  comparator8_bit u_cmp (
    .a_i  (cmp_a_d),
    .b_i  (cmp_b_d),
    .lt_i (1'b0),
    .eq_i (1'b1),
    .gt_i (1'b0),
    .lt_o (cmp_lt),
    .eq_o (cmp_eq),
    .gt_o (cmp_gt)
  );

  // Swap only on a strict order violation so ties keep arrival order.
`ifdef SORT_DESCENDING_EN
  assign swap_d = cmp_lt & ~cmp_gt & ~cmp_eq;
`else
  assign swap_d = cmp_gt & ~cmp_lt & ~cmp_eq;
`endif

  // Controller FSM with its buffer, counters and registered handshake flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_LOAD;
      buf_q[0]    <= 8'h00;
      buf_q[1]    <= 8'h00;
      buf_q[2]    <= 8'h00;
      buf_q[3]    <= 8'h00;
      ld_idx_q    <= 2'd0;
      step_q      <= 3'd0;
      out_idx_q   <= 2'd0;
      swap_cnt_q  <= 3'd0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        S_LOAD: begin
          if (bus.in_valid && in_ready_q) begin
            buf_q[ld_idx_q] <= bus.in_data;
            if (ld_idx_q == 2'd3) begin
              ld_idx_q   <= 2'd0;
              step_q     <= 3'd0;
              swap_cnt_q <= 3'd0;
              state_q    <= S_SORT;
              in_ready_q <= 1'b0;
              busy_q     <= 1'b1;
            end else begin
              ld_idx_q <= ld_idx_q + 2'd1;
            end
          end
        end
        S_SORT: begin
          if (swap_d) begin
            buf_q[pair_d]    <= cmp_b_d;
            buf_q[pair_nx_d] <= cmp_a_d;
            swap_cnt_q       <= swap_cnt_q + 3'd1;
          end
          if (step_q == 3'd5) begin
            state_q     <= S_DRAIN;
            out_idx_q   <= 2'd0;
            out_valid_q <= 1'b1;
          end else begin
            step_q <= step_q + 3'd1;
          end
        end
        S_DRAIN: begin
          if (out_valid_q && bus.out_ready) begin
            out_idx_q <= out_idx_q + 2'd1;
            if (out_idx_q == 2'd3) begin
              state_q     <= S_LOAD;
              out_valid_q <= 1'b0;
              in_ready_q  <= 1'b1;
              busy_q      <= 1'b0;
            end
          end
        end
        default: begin
          state_q     <= S_LOAD;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_valid_q ? buf_q[out_idx_q] : 8'h00;
  assign busy          = busy_q;
  assign swap_cnt      = swap_cnt_q;
endmodule

// File: tb/tb_sort4_ctrl.sv
// Directed scoreboard bench for sort4_ctrl.
// Expected bytes are queued as each batch is sent and popped on output.
module tb_sort4_ctrl;
  logic       clk;
  logic       rst_n;
  logic       busy;
  logic [2:0] swap_cnt;
  int         total;
  int         bad;
  int         cyc;
  int         n_acc;
  logic [7:0] exp_q [$];
  logic [2:0] exp_swaps;

  sort4_ctrl_if bus ();

  sort4_ctrl dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus.slave),
    .busy     (busy),
    .swap_cnt (swap_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Model: sorted order plus inversion count (= bubble swaps).
  task automatic model(input logic [7:0] b0, b1, b2, b3);
    logic [7:0] v [4];
    logic [7:0] t;
    int         inv;
    v[0] = b0; v[1] = b1; v[2] = b2; v[3] = b3;
    inv = 0;
    for (int i = 0; i < 4; i++)
      for (int j = i + 1; j < 4; j++)
`ifdef SORT_DESCENDING_EN
        if (v[i] < v[j]) inv++;
`else
        if (v[i] > v[j]) inv++;
`endif
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3 - i; j++)
`ifdef SORT_DESCENDING_EN
        if (v[j] < v[j+1]) begin
`else
        if (v[j] > v[j+1]) begin
`endif
          t = v[j]; v[j] = v[j+1]; v[j+1] = t;
        end
    for (int i = 0; i < 4; i++) exp_q.push_back(v[i]);
    exp_swaps = 3'(inv);
  endtask

  task automatic push(input logic [7:0] d);
    int w;
    bit acc;
    bus.in_data  = d;
    bus.in_valid = 1'b1;
    w = 0;
    do begin
      acc = bus.in_ready;
      tick();
      w++;
    end while (!acc && w < 50);
    if (!acc) check("accept_timeout", 32'd0, 32'd1);
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
  endtask

  task automatic load4(input logic [7:0] b0, b1, b2, b3);
    check("idle_in_ready", 32'(bus.in_ready), 32'd1);
    check("idle_busy", 32'(busy), 32'd0);
    push(b0); push(b1); push(b2); push(b3);
    n_acc = cyc;
    model(b0, b1, b2, b3);
  endtask

  task automatic drain(input int stall);
    int w;
    logic [7:0] e;
    bus.out_ready = (stall == 0);
    w = 0;
    while (!bus.out_valid && w < 30) begin
      check("sort_busy", 32'(busy), 32'd1);
      check("sort_in_ready", 32'(bus.in_ready), 32'd0);
      check("sort_out_data", 32'(bus.out_data), 32'd0);
      tick();
      w++;
    end
    check("first_valid_lat", 32'(cyc - n_acc), 32'd6);
    for (int i = 0; i < stall; i++) begin
      check("stall_data", 32'(bus.out_data), 32'(exp_q[0]));
      check("stall_valid", 32'(bus.out_valid), 32'd1);
      check("stall_in_ready", 32'(bus.in_ready), 32'd0);
      tick();
    end
    bus.out_ready = 1'b1;
    w = 0;
    while (exp_q.size() > 0 && w < 40) begin
      if (bus.out_valid) begin
        e = exp_q.pop_front();
        check("out_data", 32'(bus.out_data), 32'(e));
      end
      tick();
      w++;
    end
    if (exp_q.size() > 0) begin
      check("drain_timeout", 32'(exp_q.size()), 32'd0);
      exp_q.delete();
    end
    check("post_swap_cnt", 32'(swap_cnt), 32'(exp_swaps));
    check("post_in_ready", 32'(bus.in_ready), 32'd1);
    check("post_out_valid", 32'(bus.out_valid), 32'd0);
    check("post_busy", 32'(busy), 32'd0);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    bus.in_data   = 8'h00;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    repeat (2) tick();
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_out_data", 32'(bus.out_data), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_swap_cnt", 32'(swap_cnt), 32'd0);
    rst_n = 1'b1;
    tick();

    load4(8'h40, 8'h10, 8'h30, 8'h20);
    drain(0);
    load4(8'h01, 8'h02, 8'h03, 8'h04);
    drain(0);
    load4(8'hFF, 8'h80, 8'h7F, 8'h00);
    drain(0);
    load4(8'h05, 8'h05, 8'h03, 8'h05);
    drain(0);
    load4(8'h5A, 8'h3C, 8'hA5, 8'h00);
    drain(5);

    load4(8'h11, 8'h44, 8'h22, 8'h33);
    exp_q.delete();
    repeat (3) @(posedge clk);
    #1;
    check("mid_sort_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("rst_mid_busy", 32'(busy), 32'd0);
    check("rst_mid_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_mid_in_ready", 32'(bus.in_ready), 32'd1);
    #2;
    rst_n = 1'b1;
    tick();
    load4(8'h09, 8'h08, 8'h07, 8'h06);
    drain(0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
